// File: rtl/red_led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : red_led_pkg
//  Description : Shared defaults and counter-width helpers for the red-LED
//                driver and the board-LED tick generator.
//  Contents    : default channel count, tick divider, stretch/blink lengths,
//                PWM width, derived counter widths and a width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package red_led_pkg;

    // Default configuration: 18 LEDR channels, 1 kHz tick from a 50 MHz clock.
    localparam int N_LEDS_DEF        = 18;
    localparam int TICK_DIV_DEF      = 50000;
    localparam int STRETCH_TICKS_DEF = 100;
    localparam int BLINK_TICKS_DEF   = 250;
    localparam int PWM_BITS_DEF      = 4;

    // Width needed to hold values 0..n_states-1, never less than one bit so
    // that degenerate configurations still give a legal vector.
    function automatic int cnt_width(input int n_states);
        return (n_states < 2) ? 1 : $clog2(n_states);
    endfunction

    // Derived widths for the default configuration.
    localparam int STRETCH_W = cnt_width(STRETCH_TICKS_DEF + 1);
    localparam int TICK_W    = cnt_width(TICK_DIV_DEF);

endpackage : red_led_pkg
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_tick_gen
//  Description : Free-running prescaler producing a one-cycle slow-tick
//                strobe every TICK_DIV clock cycles. Shared by the board-LED
//                drivers so that all of them step their timers together.
//  Ports       : clk    - system clock
//                rst    - synchronous active-high reset
//                o_tick - registered one-cycle strobe, high on the cycle after
//                         the prescaler reaches TICK_DIV-1
//  Revision    : 1.0 - initial release
// ============================================================================
module led_tick_gen
    import red_led_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int                C_TICK_W = cnt_width(TICK_DIV);
    localparam logic [C_TICK_W-1:0] C_LAST = C_TICK_W'(TICK_DIV - 1);

    logic [C_TICK_W-1:0] r_count;
    logic                r_tick;
    logic                w_at_last;

    assign w_at_last = (r_count == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_at_last;
            if (w_at_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_tick = r_tick;

endmodule : led_tick_gen
`default_nettype wire

// File: rtl/red_led_driver.sv
`default_nettype none
// ============================================================================
//  Module      : red_led_driver
//  Description : Conditions the 18-bit red-LED PIO word before it reaches the
//                LEDR pins: per-LED pulse stretching so short writes remain
//                visible, global PWM brightness, per-LED blink gating and a
//                lamp-test override.
//  Ports       : clk        - system clock
//                reset      - synchronous active-high reset
//                led_word   - LED request word from the PIO out_port
//                blink_mask - 1 = LED blinks while lit
//                brightness - duty = brightness / 2^PWM_BITS, values at or
//                             above 2^PWM_BITS mean fully on, 0 means off
//                lamp_test  - forces every LED on
//                ledr       - registered LEDR pin drive
//                tick       - one-cycle slow-tick strobe for debug / sharing
//  Revision    : 1.0 - initial release
// ============================================================================
module red_led_driver
    import red_led_pkg::*;
#(
    parameter int N_LEDS        = N_LEDS_DEF,
    parameter int TICK_DIV      = TICK_DIV_DEF,
    parameter int STRETCH_TICKS = STRETCH_TICKS_DEF,
    parameter int BLINK_TICKS   = BLINK_TICKS_DEF,
    parameter int PWM_BITS      = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_LEDS-1:0]   led_word,
    input  logic [N_LEDS-1:0]   blink_mask,
    input  logic [PWM_BITS:0]   brightness,
    input  logic                lamp_test,
    output logic [N_LEDS-1:0]   ledr,
    output logic                tick
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int                     C_STRETCH_W   = cnt_width(STRETCH_TICKS + 1);
    localparam logic [C_STRETCH_W-1:0] C_STRETCH_MAX = C_STRETCH_W'(STRETCH_TICKS);
    localparam int                     C_BLINK_W     = cnt_width(BLINK_TICKS);
    localparam logic [C_BLINK_W-1:0]   C_BLINK_LAST  = C_BLINK_W'(BLINK_TICKS - 1);
    localparam logic [PWM_BITS-1:0]    C_PWM_LAST    = '1;
    // Reset brightness is "full on" so LEDs work before software sets it.
    localparam logic [PWM_BITS:0]      C_FULL_ON     = {1'b1, {PWM_BITS{1'b0}}};

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic                   w_tick;
    logic [N_LEDS-1:0]      r_led_q;
    logic [N_LEDS-1:0]      w_rise;
    logic [N_LEDS-1:0]      w_lit;
    logic [N_LEDS-1:0]      w_gate;
    logic [C_BLINK_W-1:0]   r_blink_cnt;
    logic                   r_blink_phase;
    logic [PWM_BITS-1:0]    r_pwm_cnt;
    logic [PWM_BITS:0]      r_brightness_q;
    logic                   w_pwm_on;
    logic [N_LEDS-1:0]      r_ledr;

    // ------------------------------------------------------------------------
    // Slow tick
    // ------------------------------------------------------------------------
    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (reset),
        .o_tick (w_tick)
    );

    assign tick = w_tick;

    // ------------------------------------------------------------------------
    // Input stage: one register of the PIO word, used both as the "held"
    // request and as the reference for rising-edge detection.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led_q <= '0;
        end else begin
            r_led_q <= led_word;
        end
    end

    assign w_rise = led_word & ~r_led_q;

    // ------------------------------------------------------------------------
    // Per-LED pulse stretch. The counter is parked at STRETCH_TICKS while the
    // request is high and drains one step per tick once it drops, so the LED
    // stays lit for at least STRETCH_TICKS ticks after the falling edge.
    // A rising edge reloads ahead of any coincident tick.
    // ------------------------------------------------------------------------
    generate
        if (STRETCH_TICKS > 0) begin : g_stretch
            for (genvar i = 0; i < N_LEDS; i++) begin : g_led
                logic [C_STRETCH_W-1:0] r_cnt;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_cnt <= '0;
                    end else if (r_led_q[i] || w_rise[i]) begin
                        r_cnt <= C_STRETCH_MAX;
                    end else if (w_tick && (r_cnt != '0)) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                assign w_lit[i] = r_led_q[i] | (r_cnt != '0);
            end
        end else begin : g_no_stretch
            assign w_lit = r_led_q | (w_rise & '0);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Blink: phase flips every BLINK_TICKS ticks. Unmasked LEDs ignore it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_tick) begin
            if (r_blink_cnt == C_BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_gate = ~blink_mask | {N_LEDS{r_blink_phase}};

    // ------------------------------------------------------------------------
    // PWM. Brightness is captured only on the last phase of a period so a
    // change never produces a truncated or doubled pulse mid-period.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt      <= '0;
            r_brightness_q <= C_FULL_ON;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (r_pwm_cnt == C_PWM_LAST) begin
                r_brightness_q <= brightness;
            end
        end
    end

    // The MSB alone means "at or above full scale"; otherwise compare the
    // zero-extended phase against the captured duty.
    assign w_pwm_on = r_brightness_q[PWM_BITS] | ({1'b0, r_pwm_cnt} < r_brightness_q);

    // ------------------------------------------------------------------------
    // Output register. Lamp test overrides the drive only; the stretch,
    // blink and PWM state keep running underneath it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ledr <= '0;
        end else if (lamp_test) begin
            r_ledr <= '1;
        end else begin
            r_ledr <= w_lit & w_gate & {N_LEDS{w_pwm_on}};
        end
    end

    assign ledr = r_ledr;

endmodule : red_led_driver
`default_nettype wire

// File: tb/tb_red_led_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_red_led_driver
//  Description : Self-checking bench for red_led_driver. A reference model
//                derives every expected output from the cycle count since
//                reset: tick positions, tick totals, PWM phase and blink
//                phase are computed arithmetically, stretch from the last
//                cycle each request was held.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_red_led_driver;

    localparam int N  = 18;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int BT = 2;
    localparam int PB = 2;
    localparam int PP = 1 << PB;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  led_word;
    logic [N-1:0]  blink_mask;
    logic [PB:0]   brightness;
    logic          lamp_test;
    logic [N-1:0]  ledr;
    logic          tick;

    always #5 clk = ~clk;

    red_led_driver #(
        .N_LEDS        (N),
        .TICK_DIV      (TD),
        .STRETCH_TICKS (ST),
        .BLINK_TICKS   (BT),
        .PWM_BITS      (PB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .led_word   (led_word),
        .blink_mask (blink_mask),
        .brightness (brightness),
        .lamp_test  (lamp_test),
        .ledr       (ledr),
        .tick       (tick)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: n = clock edges since reset released.
    int            n;
    logic [N-1:0]  m_led_q;
    int            m_last_high [N];
    bit            m_has_high  [N];
    int            m_bq;
    logic [N-1:0]  exp_ledr;
    logic [N-1:0]  exp_tick;

    // Number of tick strobes seen in states 0..k-1 (tick is high in states
    // TD, 2*TD, ... after reset).
    function automatic int ticks_before(input int k);
        return (k <= 1) ? 0 : (k - 1) / TD;
    endfunction

    function automatic logic [N-1:0] model_lit();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int consumed;
            consumed = 0;
            if (m_led_q[i]) begin
                r[i] = 1'b1;
            end else if (m_has_high[i] && ST > 0) begin
                consumed = ticks_before(n) - ticks_before(m_last_high[i] + 1);
                r[i] = (consumed < ST);
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Predict the next outputs from the current inputs, clock once, compare.
    task automatic step();
        if (reset) begin
            exp_ledr = '0;
            exp_tick = '0;
            n        = 0;
            m_led_q  = '0;
            m_bq     = PP;
            for (int i = 0; i < N; i++) begin
                m_has_high[i]  = 1'b0;
                m_last_high[i] = 0;
            end
        end else begin
            logic          pwm_on;
            logic          phase;
            logic [N-1:0]  gate;
            pwm_on = (m_bq >= PP) || ((n % PP) < m_bq);
            phase  = ((ticks_before(n) / BT) % 2) == 1;
            gate   = ~blink_mask | {N{phase}};
            exp_ledr = lamp_test ? '1 : (model_lit() & gate & {N{pwm_on}});
            exp_tick = {{(N-1){1'b0}}, ((n % TD) == TD - 1)};
            if ((n % PP) == PP - 1) m_bq = int'(brightness);
            for (int i = 0; i < N; i++) begin
                if (led_word[i]) begin
                    m_has_high[i]  = 1'b1;
                    m_last_high[i] = n + 1;
                end
            end
            m_led_q = led_word;
            n++;
        end
        @(posedge clk);
        #1;
        check("ledr", ledr, exp_ledr);
        check("tick", {{(N-1){1'b0}}, tick}, exp_tick);
    endtask

    initial begin
        reset      = 1'b1;
        led_word   = 18'h3FFFF;
        blink_mask = '0;
        brightness = 3'd4;
        lamp_test  = 1'b0;
        n          = 0;
        m_led_q    = '0;
        m_bq       = PP;

        // Reset, then release with all requests high.
        repeat (3) step();
        reset = 1'b0;
        step();
        step();
        check("reset_release_ledr", ledr, 18'h3FFFF);

        // Stretch: a single-cycle pulse, then a second pulse late in the drain.
        led_word = '0;
        repeat (20) step();
        check("stretch_idle", ledr, '0);
        led_word = 18'h00001;
        step();
        led_word = '0;
        repeat (6) step();
        check("stretch_hold", {{(N-1){1'b0}}, ledr[0]}, 18'h00001);
        repeat (3) step();
        led_word = 18'h00001;
        step();
        led_word = '0;
        repeat (20) step();

        // Blink: bit0 masked, bit1 steady.
        blink_mask = 18'h00001;
        led_word   = 18'h00003;
        repeat (24) step();
        check("blink_steady_bit1", {{(N-1){1'b0}}, ledr[1]}, 18'h00001);

        // PWM: 1/4 duty, change to 3/4 mid-period, then off.
        blink_mask = '0;
        led_word   = 18'h00001;
        brightness = 3'd1;
        repeat (13) step();
        brightness = 3'd3;
        repeat (13) step();
        brightness = 3'd0;
        repeat (12) step();
        check("pwm_off", ledr, '0);

        // Lamp test override and release.
        led_word   = '0;
        brightness = 3'd4;
        blink_mask = 18'h00001;
        repeat (20) step();
        lamp_test = 1'b1;
        step();
        check("lamp_on", ledr, 18'h3FFFF);
        lamp_test = 1'b0;
        step();
        check("lamp_off", ledr, '0);
        repeat (6) step();

        // Reset in the middle of a stretch.
        led_word = 18'h00001;
        step();
        led_word = '0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("reset_mid_stretch", {{(N-1){1'b0}}, ledr[0]}, '0);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) led_word = N'($urandom);
            else if ($urandom_range(0, 1) == 0) led_word = '0;
            if ($urandom_range(0, 19) == 0) blink_mask = N'($urandom);
            if ($urandom_range(0, 9) == 0) brightness = 3'($urandom_range(0, 7));
            lamp_test = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            step();
        end
        reset     = 1'b0;
        lamp_test = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_red_led_driver
`default_nettype wire
